// File: rtl/ysyx_2022040010_sram_slave_pkg.sv
// Shared types and defaults for the dual-port SRAM responder.
package ysyx_2022040010_sram_slave_pkg;

  localparam logic [63:0] SramBaseAddr = 64'h8000_0000;
  localparam int unsigned SramDepth    = 65536;
  localparam int unsigned SramWaitMax  = 7;
  localparam int unsigned CntW         = 3;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'b00,
    SRAM_WAIT = 2'b01,
    SRAM_RESP = 2'b10
  } sram_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/ysyx_2022040010_sram_port_fsm.sv
// Per-port request/response sequencer: accept, optional wait states, one-cycle response.
module ysyx_2022040010_sram_port_fsm
  import ysyx_2022040010_sram_slave_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      e_i,
  input  sram_req_t req_i,
  output sram_req_t req_c,
  output logic      resp_c,
  output logic      ready_o
);

  localparam logic [CntW-1:0] WaitLoad = (WAIT == 0) ? CntW'(0) : CntW'(WAIT - 1);

  sram_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  sram_req_t       req_q, req_d;
  logic            ready_q;
  logic            accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SRAM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= (state_d == SRAM_RESP);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    accept  = e_i && ((state_q == SRAM_IDLE) || (state_q == SRAM_RESP));
    case (state_q)
      SRAM_WAIT: begin
        if (cnt_q == '0) state_d = SRAM_RESP;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      SRAM_RESP: state_d = SRAM_IDLE;
      default:   state_d = state_q;
    endcase
    // A new request overrides the RESP->IDLE return so back-to-back traffic streams.
    if (accept) begin
      req_d = req_i;
      if (WAIT == 0) begin
        state_d = SRAM_RESP;
      end else begin
        state_d = SRAM_WAIT;
        cnt_d   = WaitLoad;
      end
    end
  end

  // With WAIT=0 the array is accessed on the accept edge, before the capture lands.
  assign req_c   = accept ? req_i : req_q;
  assign resp_c  = rst && (state_d == SRAM_RESP);
  assign ready_o = ready_q;

endmodule

// File: rtl/ysyx_2022040010_sram_slave.sv
// Dual-port memory responder: instruction-fetch port, load/store port, one shared array.
module ysyx_2022040010_sram_slave
  import ysyx_2022040010_sram_slave_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE = SramBaseAddr,
  parameter int unsigned DEPTH     = SramDepth,
  parameter int unsigned WAIT      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  output logic [31:0] isram_rdata,
  output logic        isram_ready,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [7:0]  dsram_wmask,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  output logic [63:0] dsram_rdata,
  output logic        dsram_ready,
  output logic        err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sram_req_t       i_req_in, d_req_in, i_req, d_req;
  logic            i_resp, d_resp;
  logic [63:0]     i_off, d_off, i_word, d_word;
  logic [IdxW-1:0] i_idx, d_idx;
  logic            i_fault, d_fault, d_commit;
  logic [31:0]     i_rdata_q;
  logic [63:0]     d_rdata_q;
  logic            err_q;
  logic            unused_i;
  logic [63:0]     mem_q [DEPTH];

  assign i_req_in = '{addr: isram_addr, we: 1'b0, wmask: 8'h00, wdata: 64'h0};
  assign d_req_in = '{addr: dsram_addr, we: dsram_we, wmask: dsram_wmask, wdata: dsram_wdata};

  ysyx_2022040010_sram_port_fsm #(.WAIT(WAIT)) u_ifsm (
    .clk    (clk),
    .rst    (rst),
    .e_i    (isram_e),
    .req_i  (i_req_in),
    .req_c  (i_req),
    .resp_c (i_resp),
    .ready_o(isram_ready)
  );

  ysyx_2022040010_sram_port_fsm #(.WAIT(WAIT)) u_dfsm (
    .clk    (clk),
    .rst    (rst),
    .e_i    (dsram_e),
    .req_i  (d_req_in),
    .req_c  (d_req),
    .resp_c (d_resp),
    .ready_o(dsram_ready)
  );

  assign unused_i = ^{i_req.we, i_req.wmask, i_req.wdata};

  // Address decode and fault detection; the wrapped offset is harmless since low addrs fault anyway.
  assign i_off   = i_req.addr - ADDR_BASE;
  assign d_off   = d_req.addr - ADDR_BASE;
  assign i_word  = i_off >> 3;
  assign d_word  = d_off >> 3;
  assign i_idx   = i_word[IdxW-1:0];
  assign d_idx   = d_word[IdxW-1:0];
  assign i_fault = (i_req.addr < ADDR_BASE) || (i_word >= 64'(DEPTH)) || (i_req.addr[1:0] != 2'b00);
  assign d_fault = (d_req.addr < ADDR_BASE) || (d_word >= 64'(DEPTH));
  assign d_commit = d_resp && d_req.we && !d_fault;

  // Array contents survive reset; only byte lanes with a strobe are written.
  always_ff @(posedge clk) begin
    if (d_commit) begin
      for (int k = 0; k < 8; k++) begin
        if (d_req.wmask[k]) mem_q[d_idx][8*k +: 8] <= d_req.wdata[8*k +: 8];
      end
    end
  end

  // Reads sample pre-write contents, so a same-edge I-read sees the old word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (i_resp) begin
        i_rdata_q <= i_fault ? 32'h0 :
                     (i_req.addr[2] ? mem_q[i_idx][63:32] : mem_q[i_idx][31:0]);
      end
      if (d_resp) d_rdata_q <= (d_fault || d_req.we) ? 64'h0 : mem_q[d_idx];
      if ((i_resp && i_fault) || (d_resp && d_fault)) err_q <= 1'b1;
    end
  end

  assign isram_rdata = i_rdata_q;
  assign dsram_rdata = d_rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ysyx_2022040010_sram_slave.sv
// Bench: three responders (WAIT=0/3/5) driven by vector tables, a scoreboard and hand sequences.
module tb_ysyx_2022040010_sram_slave;

  typedef struct {
    bit          iport;
    bit          we;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  logic             clk;
  logic [2:0]       rst, isram_e, dsram_e, dsram_we;
  logic [2:0]       isram_ready, dsram_ready, err;
  logic [2:0][63:0] isram_addr, dsram_addr, dsram_wdata, dsram_rdata;
  logic [2:0][31:0] isram_rdata;
  logic [2:0][7:0]  dsram_wmask;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] iq[$];
  logic [63:0] dq[$];
  vec_t        tbl[15];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    ysyx_2022040010_sram_slave #(.ADDR_BASE(64'h8000_0000), .DEPTH(1024), .WAIT(W)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .isram_e    (isram_e[g]),
      .isram_addr (isram_addr[g]),
      .isram_rdata(isram_rdata[g]),
      .isram_ready(isram_ready[g]),
      .dsram_e    (dsram_e[g]),
      .dsram_we   (dsram_we[g]),
      .dsram_wmask(dsram_wmask[g]),
      .dsram_addr (dsram_addr[g]),
      .dsram_wdata(dsram_wdata[g]),
      .dsram_rdata(dsram_rdata[g]),
      .dsram_ready(dsram_ready[g]),
      .err        (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard for the WAIT=0 instance: every ready pops one expected word.
  always @(negedge clk) begin
    logic [63:0] e_i, e_d;
    if (isram_ready[0]) begin
      if (iq.size() == 0) check("i ready with empty queue", 64'(isram_ready[0]), 64'd0);
      else begin
        e_i = iq.pop_front();
        check("i rdata sb", 64'(isram_rdata[0]), e_i);
      end
    end
    if (dsram_ready[0]) begin
      if (dq.size() == 0) check("d ready with empty queue", 64'(dsram_ready[0]), 64'd0);
      else begin
        e_d = dq.pop_front();
        check("d rdata sb", dsram_rdata[0], e_d);
      end
    end
  end

  task automatic drive0(input vec_t v);
    @(posedge clk); #1;
    isram_e[0] = 1'b0;
    dsram_e[0] = 1'b0;
    if (v.iport) begin
      isram_e[0] = 1'b1; isram_addr[0] = v.addr;
      iq.push_back(v.exp);
    end else begin
      dsram_e[0] = 1'b1; dsram_we[0] = v.we; dsram_addr[0] = v.addr;
      dsram_wmask[0] = v.mask; dsram_wdata[0] = v.wdata;
      dq.push_back(v.exp);
    end
  endtask

  task automatic idle0();
    @(posedge clk); #1;
    isram_e[0] = 1'b0;
    dsram_e[0] = 1'b0;
  endtask

  // Single request on instance g; measures cycles from request cycle to ready.
  task automatic req_lat(input int g, input bit iport, input bit we, input logic [63:0] addr,
                         input logic [7:0] mask, input logic [63:0] wd, input int exp_lat,
                         input logic [63:0] exp_data, input string name);
    int lat, pulses;
    logic [63:0] got;
    lat = -1; pulses = 0; got = '0;
    @(posedge clk); #1;
    if (iport) begin
      isram_e[g] = 1'b1; isram_addr[g] = addr;
    end else begin
      dsram_e[g] = 1'b1; dsram_we[g] = we; dsram_addr[g] = addr;
      dsram_wmask[g] = mask; dsram_wdata[g] = wd;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin isram_e[g] = 1'b0; dsram_e[g] = 1'b0; end
      if (iport ? isram_ready[g] : dsram_ready[g]) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = iport ? 64'(isram_rdata[g]) : dsram_rdata[g];
        end
      end
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " pulses"}, 64'(pulses), 64'd1);
    check({name, " rdata"}, got, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] obs;
    int          stray;
    rst = '0; isram_e = '0; dsram_e = '0; dsram_we = '0; dsram_wmask = '0;
    isram_addr = '0; dsram_addr = '0; dsram_wdata = '0;

    tbl[0]  = '{0, 1, 64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    tbl[1]  = '{0, 1, 64'h8000_0010, 8'hFF, 64'h0, 64'h0};
    tbl[2]  = '{0, 1, 64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[3]  = '{0, 0, 64'h8000_0010, 8'h00, 64'h0, 64'h0000_0000_FFFF_FFFF};
    tbl[4]  = '{0, 1, 64'h8000_0018, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
    tbl[5]  = '{0, 1, 64'h8000_001D, 8'hF0, 64'h0123_4567_89AB_CDEF, 64'h0};
    tbl[6]  = '{0, 0, 64'h8000_0018, 8'h00, 64'h0, 64'h0123_4567_AAAA_AAAA};
    tbl[7]  = '{0, 1, 64'h8000_0018, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[8]  = '{0, 0, 64'h8000_0018, 8'h00, 64'h0, 64'h0123_4567_AAAA_AAAA};
    tbl[9]  = '{1, 0, 64'h8000_0004, 8'h00, 64'h0, 64'h0000_0000_1122_3344};
    tbl[10] = '{1, 0, 64'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_5566_7788};
    tbl[11] = '{0, 0, 64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788};
    tbl[12] = '{0, 0, 64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0};
    tbl[13] = '{0, 1, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[14] = '{0, 0, 64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset i_ready[%0d]", g), 64'(isram_ready[g]), 64'd0);
      check($sformatf("reset d_ready[%0d]", g), 64'(dsram_ready[g]), 64'd0);
      check($sformatf("reset i_rdata[%0d]", g), 64'(isram_rdata[g]), 64'd0);
      check($sformatf("reset d_rdata[%0d]", g), dsram_rdata[g], 64'd0);
      check($sformatf("reset err[%0d]", g), 64'(err[g]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 3'b111;

    // WAIT=0: back-to-back vectors, one per cycle.
    for (int i = 0; i < 12; i++) drive0(tbl[i]);
    idle0();
    repeat (2) @(negedge clk);
    check("err clean before faults", 64'(err[0]), 64'd0);

    // Same-edge I-read and D-write of one word.
    drive0('{0, 1, 64'h8000_0020, 8'hFF, 64'hA, 64'h0});
    drive0('{0, 1, 64'h8000_0020, 8'hFF, 64'hB, 64'h0});
    isram_e[0] = 1'b1; isram_addr[0] = 64'h8000_0020; iq.push_back(64'hA);
    drive0('{1, 0, 64'h8000_0020, 8'h00, 64'h0, 64'hB});
    idle0();

    for (int i = 12; i < 15; i++) drive0(tbl[i]);
    idle0();
    repeat (3) @(negedge clk);
    check("err sticky after faults", 64'(err[0]), 64'd1);
    check("scoreboard drained", 64'(iq.size() + dq.size()), 64'd0);

    // WAIT=3: latency, throughput with e held, misaligned fetch fault.
    req_lat(1, 0, 1, 64'h8000_0040, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 4, 64'h0, "w3 write");
    req_lat(1, 0, 0, 64'h8000_0040, 8'h00, 64'h0, 4, 64'hDEAD_BEEF_CAFE_F00D, "w3 read");
    req_lat(1, 1, 0, 64'h8000_0044, 8'h00, 64'h0, 4, 64'h0000_0000_DEAD_BEEF, "w3 fetch");
    @(posedge clk); #1;
    dsram_e[1] = 1'b1; dsram_we[1] = 1'b0; dsram_addr[1] = 64'h8000_0040;
    obs = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      obs[k] = dsram_ready[1];
      if (k == 12) dsram_e[1] = 1'b0;
    end
    check("w3 throughput pattern", 64'(obs), 64'h1110);
    check("w3 streamed rdata", dsram_rdata[1], 64'hDEAD_BEEF_CAFE_F00D);
    repeat (6) @(negedge clk);
    check("w3 err before fault", 64'(err[1]), 64'd0);
    req_lat(1, 1, 0, 64'h8000_0002, 8'h00, 64'h0, 4, 64'h0, "w3 misaligned fetch");
    check("w3 err after misaligned", 64'(err[1]), 64'd1);

    // WAIT=5: reset in the middle of a pending write drops it.
    req_lat(2, 0, 1, 64'h8000_0080, 8'hFF, 64'h5555_5555_5555_5555, 6, 64'h0, "w5 write");
    req_lat(2, 0, 0, 64'h8000_0080, 8'h00, 64'h0, 6, 64'h5555_5555_5555_5555, "w5 read");
    @(posedge clk); #1;
    dsram_e[2] = 1'b1; dsram_we[2] = 1'b1; dsram_addr[2] = 64'h8000_0080;
    dsram_wmask[2] = 8'hFF; dsram_wdata[2] = 64'h9999_9999_9999_9999;
    @(posedge clk); #1;
    dsram_e[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b1;
    @(negedge clk);
    check("w5 d_ready after reset", 64'(dsram_ready[2]), 64'd0);
    check("w5 i_ready after reset", 64'(isram_ready[2]), 64'd0);
    check("w5 d_rdata after reset", dsram_rdata[2], 64'd0);
    check("w5 err after reset", 64'(err[2]), 64'd0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dsram_ready[2] || isram_ready[2]) stray++;
    end
    check("w5 no response after reset", 64'(stray), 64'd0);
    req_lat(2, 0, 0, 64'h8000_0080, 8'h00, 64'h0, 6, 64'h5555_5555_5555_5555, "w5 word kept");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
